// File: rtl/cpc_bus_cycle_decoder_if.sv
// Z80 bus bundle seen by the 512K expansion CPLD front end.
//
// Signals (all driven by the Z80 side, sampled by the decoder):
//   mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b : raw controls, active low
//   adr15, adr8                              : address bits used for port decode
//   data[7:0]                                : data bus
//
// Modports:
//   master : the CPU / bus driver
//   slave  : the cycle decoder
interface cpc_bus_cycle_decoder_if;
    logic       mreq_b;
    logic       iorq_b;
    logic       rd_b;
    logic       wr_b;
    logic       m1_b;
    logic       rfsh_b;
    logic       adr15;
    logic       adr8;
    logic [7:0] data;

    modport master (
        output mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr8, data
    );

    modport slave (
        input mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr8, data
    );
endinterface

// File: rtl/cpc_bus_cycle_decoder.sv
// Front-end stage of the 512K expansion CPLD.
//
// Registers the raw Z80 bus, classifies each bus cycle with a small FSM and
// produces registered cycle-type levels plus a one-clock strobe when a
// DK'Tronics/Amstrad bank-select write (OUT &7Fxx/&7Exx, data 0b11cccbbb) is
// accepted. The accepted value is latched into ramblock/mode3/cardsel.
//
// Ports:
//   clk             CPU clock, rising edge
//   reset           asynchronous, active-high
//   bus             Z80 bus (slave modport of cpc_bus_cycle_decoder_if)
//   low512kb_mode   1: card answers on &7Exx, 0: on &7Fxx
//   shadow_mode     enables aliasing of the shadow bank in ramblock
//   shadow_bank     64K bank reserved for shadow memory
//   mrd_cyc         level, memory read (incl. M1 fetch) in progress
//   mwr_cyc         level, memory write in progress
//   rfsh_cyc        level, refresh cycle in progress
//   iowr_stb        one-clock pulse, bank-select write accepted
//   ramblock        latched {ccc,bbb}, shadow-aliased
//   mode3           latched bbb == 3'b011
//   cardsel         last accepted write addressed this card's port
//   bankwr_cnt      saturating count of accepted bank writes
//
// Build option:
//   CYCLE_DEGLITCH_EN  when defined, IO_PEND -> IOWR needs IORQ and WR low on
//                      two consecutive samples; a one-sample WR glitch is ignored.
module cpc_bus_cycle_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    cpc_bus_cycle_decoder_if.slave bus,
    input  logic                   low512kb_mode,
    input  logic                   shadow_mode,
    input  logic [2:0]             shadow_bank,
    output logic                   mrd_cyc,
    output logic                   mwr_cyc,
    output logic                   rfsh_cyc,
    output logic                   iowr_stb,
    output logic [5:0]             ramblock,
    output logic                   mode3,
    output logic                   cardsel,
    output logic [CNT_W-1:0]       bankwr_cnt
);

    typedef enum logic [3:0] {
        StIdle,
        StMemPend,
        StIoPend,
        StMrd,
        StMwr,
        StIord,
        StIowr,
        StInta,
        StRfsh
    } state_e;

    state_e state_q, state_d;

    logic       mreq_b_q, iorq_b_q, rd_b_q, wr_b_q, m1_b_q, rfsh_b_q;
    logic       adr15_q, adr8_q;
    logic [7:0] data_q;

    // sampled_q: at least one real bus sample has been taken since reset.
    // armed_q: the bus has been seen idle since reset, so a cycle cut by reset
    // is never picked up half-way.
    logic sampled_q;
    logic armed_q, armed_d;

    logic       released;
    logic       bank_hit;
    logic       io_wr_go;
    logic       accept;
    logic [2:0] ccc_alias;
    logic [5:0] ramblock_d;

    // Input stage: every control, address and data pin is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mreq_b_q  <= 1'b1;
            iorq_b_q  <= 1'b1;
            rd_b_q    <= 1'b1;
            wr_b_q    <= 1'b1;
            m1_b_q    <= 1'b1;
            rfsh_b_q  <= 1'b1;
            adr15_q   <= 1'b0;
            adr8_q    <= 1'b0;
            data_q    <= 8'h00;
            sampled_q <= 1'b0;
        end else begin
            mreq_b_q  <= bus.mreq_b;
            iorq_b_q  <= bus.iorq_b;
            rd_b_q    <= bus.rd_b;
            wr_b_q    <= bus.wr_b;
            m1_b_q    <= bus.m1_b;
            rfsh_b_q  <= bus.rfsh_b;
            adr15_q   <= bus.adr15;
            adr8_q    <= bus.adr8;
            data_q    <= bus.data;
            sampled_q <= 1'b1;
        end
    end

    assign released = mreq_b_q & iorq_b_q;
    assign armed_d  = armed_q | (sampled_q & released);
    assign bank_hit = ~adr15_q & (data_q[7:6] == 2'b11);

`ifdef CYCLE_DEGLITCH_EN
    logic wr_qual_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_qual_prev_q <= 1'b0;
        end else begin
            wr_qual_prev_q <= ~iorq_b_q & ~wr_b_q;
        end
    end

    assign io_wr_go = ~iorq_b_q & ~wr_b_q & wr_qual_prev_q;
`else
    assign io_wr_go = ~wr_b_q;
`endif

    // Shadow aliasing clears the low bit of the 64K bank field.
    always_comb begin
        ccc_alias = data_q[5:3];
        if (shadow_mode && (data_q[5:3] == shadow_bank)) begin
            ccc_alias[0] = 1'b0;
        end
        ramblock_d = {ccc_alias, data_q[2:0]};
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q) begin
                    if (!rfsh_b_q) begin
                        state_d = StRfsh;
                    end else if (!iorq_b_q && !m1_b_q) begin
                        state_d = StInta;
                    end else if (!mreq_b_q) begin
                        state_d = StMemPend;
                    end else if (!iorq_b_q) begin
                        state_d = StIoPend;
                    end
                end
            end
            StMemPend: begin
                if (released) begin
                    state_d = StIdle;
                end else if (!rd_b_q) begin
                    state_d = StMrd;
                end else if (!wr_b_q) begin
                    state_d = StMwr;
                end
            end
            StIoPend: begin
                if (released) begin
                    state_d = StIdle;
                end else if (!rd_b_q) begin
                    state_d = StIord;
                end else if (io_wr_go) begin
                    // Accept only on entry, so one IO cycle gives at most one strobe.
                    state_d = StIowr;
                    accept  = bank_hit;
                end
            end
            default: begin
                if (released) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            mrd_cyc    <= 1'b0;
            mwr_cyc    <= 1'b0;
            rfsh_cyc   <= 1'b0;
            iowr_stb   <= 1'b0;
            ramblock   <= 6'b0;
            mode3      <= 1'b0;
            cardsel    <= 1'b0;
            bankwr_cnt <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            mrd_cyc  <= (state_d == StMrd);
            mwr_cyc  <= (state_d == StMwr);
            rfsh_cyc <= (state_d == StRfsh);
            iowr_stb <= accept;
            if (accept) begin
                ramblock <= ramblock_d;
                mode3    <= (data_q[2:0] == 3'b011);
                cardsel  <= low512kb_mode ? ~adr8_q : adr8_q;
                if (bankwr_cnt != {CNT_W{1'b1}}) begin
                    bankwr_cnt <= bankwr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
module tb_cpc_bus_cycle_decoder;

    localparam int unsigned CntW   = 8;
    localparam int          CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            low512kb_mode = 1'b0;
    logic            shadow_mode = 1'b0;
    logic [2:0]      shadow_bank = 3'b000;
    logic            mrd_cyc, mwr_cyc, rfsh_cyc, iowr_stb, mode3, cardsel;
    logic [5:0]      ramblock;
    logic [CntW-1:0] bankwr_cnt;

    cpc_bus_cycle_decoder_if bus_if ();

    cpc_bus_cycle_decoder #(
        .CNT_W(CntW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .low512kb_mode(low512kb_mode),
        .shadow_mode  (shadow_mode),
        .shadow_bank  (shadow_bank),
        .mrd_cyc      (mrd_cyc),
        .mwr_cyc      (mwr_cyc),
        .rfsh_cyc     (rfsh_cyc),
        .iowr_stb     (iowr_stb),
        .ramblock     (ramblock),
        .mode3        (mode3),
        .cardsel      (cardsel),
        .bankwr_cnt   (bankwr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0] rb;
        logic       m3;
        logic       cs;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state of the card, updated per accepted OUT.
    logic [5:0] m_rb  = 6'b0;
    logic       m_m3  = 1'b0;
    logic       m_cs  = 1'b0;
    int         m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rest();
        bus_if.mreq_b = 1'b1;
        bus_if.iorq_b = 1'b1;
        bus_if.rd_b   = 1'b1;
        bus_if.wr_b   = 1'b1;
        bus_if.m1_b   = 1'b1;
        bus_if.rfsh_b = 1'b1;
    endtask

    task automatic model_reset();
        m_rb  = 6'b0;
        m_m3  = 1'b0;
        m_cs  = 1'b0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // What the card must do for one OUT, given the current mode inputs.
    task automatic model_write(input logic a15, input logic a8, input logic [7:0] d);
        exp_t e;
        int   bank;
        int   blk;
        if (a15 == 1'b0 && d[7:6] == 2'b11) begin
            bank = int'(d[5:3]);
            blk  = int'(d[2:0]);
            if (shadow_mode && bank == int'(shadow_bank)) bank = bank - (bank % 2);
            m_rb  = 6'(bank * 8 + blk);
            m_m3  = (blk == 3);
            m_cs  = low512kb_mode ? !a8 : a8;
            m_cnt = (m_cnt < CntMax) ? m_cnt + 1 : CntMax;
            e.rb  = m_rb;
            e.m3  = m_m3;
            e.cs  = m_cs;
            e.cnt = m_cnt;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding accept.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && iowr_stb) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_iowr_stb", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stb_ramblock", 32'(ramblock), 32'(e.rb));
                chk("stb_mode3", 32'(mode3), 32'(e.m3));
                chk("stb_cardsel", 32'(cardsel), 32'(e.cs));
                chk("stb_bankwr_cnt", 32'(bankwr_cnt), 32'(e.cnt));
            end
        end
    end

    // Z80 OUT: address/data in T1, IORQ+WR low from T2, released after the wait.
    task automatic io_write(input logic a15, input logic a8, input logic [7:0] d);
        bus_if.adr15 = a15;
        bus_if.adr8  = a8;
        bus_if.data  = d;
        model_write(a15, a8, d);
        step();
        bus_if.iorq_b = 1'b0;
        bus_if.wr_b   = 1'b0;
        repeat (4) step();
        bus_if.iorq_b = 1'b1;
        bus_if.wr_b   = 1'b1;
        repeat (3) step();
    endtask

    // kind 0: read, 1: write, 2: refresh. MREQ (or RFSH) low from e=0 to hold-1,
    // RD/WR low from rw_delay. A level rises one edge after its strobe is seen
    // (but never before the pending edge) and falls two edges after release.
    task automatic mem_cycle(input int kind, input int rw_delay, input int hold, input logic m1);
        int act;
        logic exp_rd, exp_wr, exp_rf;
        act = (kind == 2) ? 2 : ((rw_delay + 2 > 3) ? rw_delay + 2 : 3);
        for (int e = 0; e <= hold + 3; e++) begin
            bus_if.mreq_b = !(e < hold);
            bus_if.rfsh_b = !(kind == 2 && e < hold);
            bus_if.m1_b   = !(m1 && e < hold);
            bus_if.rd_b   = !(kind == 0 && e >= rw_delay && e < hold);
            bus_if.wr_b   = !(kind == 1 && e >= rw_delay && e < hold);
            @(negedge clk);
            exp_rd = (kind == 0) && (e >= act) && (e < hold + 2);
            exp_wr = (kind == 1) && (e >= act) && (e < hold + 2);
            exp_rf = (kind == 2) && (e >= act) && (e < hold + 2);
            chk("mrd_cyc", 32'(mrd_cyc), 32'(exp_rd));
            chk("mwr_cyc", 32'(mwr_cyc), 32'(exp_wr));
            chk("rfsh_cyc", 32'(rfsh_cyc), 32'(exp_rf));
            step();
        end
        bus_rest();
        step();
    endtask

    task automatic check_all_clear(input string tag);
        chk({tag, "_mrd"}, 32'(mrd_cyc), 32'd0);
        chk({tag, "_mwr"}, 32'(mwr_cyc), 32'd0);
        chk({tag, "_rfsh"}, 32'(rfsh_cyc), 32'd0);
        chk({tag, "_stb"}, 32'(iowr_stb), 32'd0);
        chk({tag, "_ramblock"}, 32'(ramblock), 32'd0);
        chk({tag, "_mode3"}, 32'(mode3), 32'd0);
        chk({tag, "_cardsel"}, 32'(cardsel), 32'd0);
        chk({tag, "_cnt"}, 32'(bankwr_cnt), 32'd0);
    endtask

    initial begin
        logic       a15, a8;
        logic [7:0] d;

        bus_rest();
        bus_if.adr15 = 1'b1;
        bus_if.adr8  = 1'b1;
        bus_if.data  = 8'h00;
        #1;
        check_all_clear("in_reset");
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        check_all_clear("after_reset");

        // Directed bank writes.
        low512kb_mode = 1'b0; shadow_mode = 1'b0; shadow_bank = 3'b000;
        io_write(1'b0, 1'b1, 8'hC6);
        chk("c6_ramblock", 32'(ramblock), 32'h06);
        chk("c6_cnt", 32'(bankwr_cnt), 32'd1);

        low512kb_mode = 1'b1; shadow_mode = 1'b1; shadow_bank = 3'b011;
        io_write(1'b0, 1'b0, 8'hDB);
        chk("db_ramblock", 32'(ramblock), 32'h13);
        chk("db_mode3", 32'(mode3), 32'd1);
        chk("db_cardsel", 32'(cardsel), 32'd1);
        low512kb_mode = 1'b0;
        io_write(1'b0, 1'b0, 8'hDB);
        chk("db_cardsel_low0", 32'(cardsel), 32'd0);

        // Rejected writes: wrong port, wrong data prefix.
        io_write(1'b1, 1'b1, 8'hC3);
        io_write(1'b0, 1'b1, 8'h43);
        chk("reject_ramblock", 32'(ramblock), 32'(m_rb));
        chk("reject_cnt", 32'(bankwr_cnt), 32'(m_cnt));

        // Memory / refresh cycle classification.
        mem_cycle(1, 1, 3, 1'b0);  // write: MREQ T1, WR T2
        mem_cycle(1, 2, 4, 1'b0);  // write with late WR
        mem_cycle(0, 0, 3, 1'b0);  // read
        mem_cycle(0, 0, 2, 1'b1);  // M1 opcode fetch
        mem_cycle(2, 0, 2, 1'b0);  // refresh

        // Randomized bank writes.
        for (int i = 0; i < 40; i++) begin
            a15 = ($urandom_range(0, 3) == 0);
            a8  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
            low512kb_mode = 1'($urandom_range(0, 1));
            shadow_mode   = 1'($urandom_range(0, 1));
            shadow_bank   = ($urandom_range(0, 1) == 1) ? d[5:3] : 3'($urandom_range(0, 7));
            io_write(a15, a8, d);
            if (i % 8 == 7) mem_cycle(1, 1, 3, 1'b0);
        end
        chk("rand_ramblock", 32'(ramblock), 32'(m_rb));
        chk("rand_cnt", 32'(bankwr_cnt), 32'(m_cnt));

        // WR glitch inside a long IORQ, then a one-clock IORQ+WR pulse.
        low512kb_mode = 1'b0; shadow_mode = 1'b0;
        bus_if.adr15 = 1'b0; bus_if.adr8 = 1'b1; bus_if.data = 8'hC9;
`ifndef CYCLE_DEGLITCH_EN
        model_write(1'b0, 1'b1, 8'hC9);
`endif
        step();
        bus_if.iorq_b = 1'b0;
        step();
        bus_if.wr_b = 1'b0;
        step();
        bus_if.wr_b = 1'b1;
        repeat (3) step();
        bus_if.iorq_b = 1'b1;
        repeat (3) step();
        bus_if.data = 8'hCA;
        bus_if.iorq_b = 1'b0; bus_if.wr_b = 1'b0;
        step();
        bus_if.iorq_b = 1'b1; bus_if.wr_b = 1'b1;
        repeat (4) step();
        chk("glitch_cnt", 32'(bankwr_cnt), 32'(m_cnt));
        chk("glitch_ramblock", 32'(ramblock), 32'(m_rb));

        // Reset in the middle of an accepted IOWR.
        bus_if.adr15 = 1'b0; bus_if.adr8 = 1'b1; bus_if.data = 8'hC5;
        model_write(1'b0, 1'b1, 8'hC5);
        step();
        bus_if.iorq_b = 1'b0; bus_if.wr_b = 1'b0;
        repeat (4) step();
        #2 reset = 1'b1;
        #1 check_all_clear("async_reset");
        model_reset();
        step();
        reset = 1'b0;
        repeat (4) step();  // remainder of the cut cycle must be ignored
        bus_rest();
        repeat (4) step();
        chk("post_reset_cnt", 32'(bankwr_cnt), 32'd0);
        chk("post_reset_ramblock", 32'(ramblock), 32'd0);

        // Saturation of the accept counter.
        for (int i = 0; i < CntMax + 3; i++) begin
            io_write(1'b0, 1'b1, 8'hC0 | 8'(i % 64));
        end
        chk("sat_cnt", 32'(bankwr_cnt), 32'(CntMax));

        repeat (5) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
